sdram_wbuf: RTL and testbench



---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_wbuf_fifo.sv | 62 ++++++
 rtl/sdram_wbuf.sv | 144 ++++++++++++++
 tb/tb_sdram_wbuf.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM write-posting front end:
// engine states, queued write entries and the depth limit.
package sdram_pkg;

  localparam int WBUF_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    GAP
  } wbuf_state_t;

  typedef struct packed {
    logic [24:1] addr;
    logic [1:0]  be;
    logic [15:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/sdram_wbuf_fifo.sv
// Posted-write queue for sdram_wbuf. With SDRAM_WBUF_FWD_EN it also
// exposes its live entries, oldest first, for read forwarding.
module wbuf_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  wbuf_entry_t din,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output wbuf_entry_t head
`ifdef SDRAM_WBUF_FWD_EN
  ,
  output wbuf_entry_t view [DEPTH],
  output logic [AW:0] level
`endif
);

  wbuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

`ifdef SDRAM_WBUF_FWD_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      view[i] = mem[rd_ptr + AW'(i)];
  end

  assign level = cnt;
`endif

endmodule

// File: rtl/sdram_wbuf.sv
// Write-posting front end for one SDRAM controller port.
// Define SDRAM_WBUF_FWD_EN to answer reads from full-word queued writes.
module sdram_wbuf
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_rd,
  output logic        ram_wrl,
  output logic        ram_wrh,
  input  logic [15:0] ram_dout,
  input  logic        ram_busy
);

  wbuf_state_t state, state_nx;
  wbuf_entry_t head, wr_ent;
  logic        full, empty, push, pop;
  logic        op_rd, rd_req;
  logic        issue_wr, issue_rd, done;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  assign rd_req = cpu_req & ~cpu_we & ~cpu_ack;
  assign push   = cpu_req & cpu_we & ~cpu_ack & ~full;
  assign pop    = done & ~op_rd;
  assign wr_ent = '{addr: cpu_addr, be: cpu_be, data: cpu_wdata};

`ifdef SDRAM_WBUF_FWD_EN
  localparam int AW = $clog2(DEPTH);
  wbuf_entry_t view [DEPTH];
  logic [AW:0] level;
  logic        fwd_full;

  // Later (newer) matches override older ones.
  always_comb begin
    fwd_full = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < level && view[i].addr == cpu_addr) begin
        fwd_full = (view[i].be == 2'b11);
        fwd_data = view[i].data;
      end
    end
  end

  assign fwd_hit = rd_req & fwd_full;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  wbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wr_ent),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
`ifdef SDRAM_WBUF_FWD_EN
    ,
    .view  (view),
    .level (level)
`endif
  );

  always_comb begin
    state_nx = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          issue_wr = 1'b1;
          state_nx = ISSUE;
        end else if (rd_req) begin
          issue_rd = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: if (ram_busy) state_nx = BUSY;
      BUSY: begin
        if (!ram_busy) begin
          done     = 1'b1;
          state_nx = GAP;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_rd     <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_rd    <= 1'b0;
      ram_wrl   <= 1'b0;
      ram_wrh   <= 1'b0;
    end else begin
      state   <= state_nx;
      cpu_ack <= push | fwd_hit | (state == GAP && op_rd);
      if (fwd_hit) cpu_rdata <= fwd_data;
      if (issue_wr) begin
        ram_addr <= head.addr;
        ram_din  <= head.data;
        ram_wrl  <= head.be[0];
        ram_wrh  <= head.be[1];
        op_rd    <= 1'b0;
      end
      if (issue_rd) begin
        ram_addr <= cpu_addr;
        ram_rd   <= 1'b1;
        op_rd    <= 1'b1;
      end
      if (done) begin
        ram_rd  <= 1'b0;
        ram_wrl <= 1'b0;
        ram_wrh <= 1'b0;
        if (op_rd) cpu_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_wbuf.sv
// Directed bench for sdram_wbuf against a busy-handshake SDRAM port model.
// Forwarding cases run only when SDRAM_WBUF_FWD_EN is defined.
module tb_sdram_wbuf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [23:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_rd, ram_wrl, ram_wrh;
  logic [15:0] ram_dout = '0;
  logic        ram_busy = 1'b0;

  always #5 clk = ~clk;

  sdram_wbuf #(
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_rd    (ram_rd),
    .ram_wrl   (ram_wrl),
    .ram_wrh   (ram_wrh),
    .ram_dout  (ram_dout),
    .ram_busy  (ram_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Controller port model: busy rises the cycle after a strobe edge
  // and stays high for blen cycles.
  logic        stb;
  logic        stb_q = 1'b0;
  int          blen = 3;
  int          bcnt = 0;
  logic [15:0] mem [4096];

  assign stb = ram_rd | ram_wrl | ram_wrh;

  always @(posedge clk) begin
    if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) ram_busy <= 1'b0;
    end else if (stb && !stb_q) begin
      ram_busy <= 1'b1;
      bcnt     <= blen;
      if (ram_rd)  ram_dout <= mem[ram_addr[11:0]];
      if (ram_wrl) mem[ram_addr[11:0]][7:0]  <= ram_din[7:0];
      if (ram_wrh) mem[ram_addr[11:0]][15:8] <= ram_din[15:8];
    end
    stb_q <= stb;
  end

  typedef struct {
    logic [23:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wrl;
    logic        wrh;
    int          rise;
    int          fall;
    bit          moved;
  } ev_t;

  ev_t  evq[$];
  ev_t  ev_tmp;
  int   cyc = 0;
  int   acks = 0;
  int   rds = 0;
  logic stb_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (stb && !stb_p) begin
      ev_tmp.addr  = ram_addr;
      ev_tmp.din   = ram_din;
      ev_tmp.rd    = ram_rd;
      ev_tmp.wrl   = ram_wrl;
      ev_tmp.wrh   = ram_wrh;
      ev_tmp.rise  = cyc;
      ev_tmp.fall  = 0;
      ev_tmp.moved = 1'b0;
      evq.push_back(ev_tmp);
      if (ram_rd) rds++;
    end else if (stb && stb_p) begin
      if (ram_addr != evq[evq.size()-1].addr ||
          ram_din != evq[evq.size()-1].din ||
          ram_wrl != evq[evq.size()-1].wrl ||
          ram_wrh != evq[evq.size()-1].wrh)
        evq[evq.size()-1].moved = 1'b1;
    end
    if (!stb && stb_p) evq[evq.size()-1].fall = cyc;
    if (cpu_ack) acks++;
    stb_p = stb;
  end

  task automatic cpu_write(input logic [23:0] a, input logic [1:0] be,
                           input logic [15:0] d, output int lat);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_be    = be;
    cpu_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 400);
    check("wr_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic cpu_read(input logic [23:0] a, output logic [15:0] d,
                          output int lat);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = a;
    cpu_be   = 2'b00;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 400);
    check("rd_ack", 32'(cpu_ack), 1);
    d = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  task automatic settle();
    int q = 0;
    int n = 0;
    while (q < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!stb && !ram_busy) q++;
      else q = 0;
    end
    check("settle", 32'(q >= 4), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int b;
    int n;
    int a0;
    int r0;
    logic [15:0] d;

    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(cpu_ack), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_stb", 32'({ram_rd, ram_wrl, ram_wrh}), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_din", 32'(ram_din), 0);
    reset = 1'b0;

    // single full write
    blen = 3;
    b = evq.size();
    cpu_write(24'h000100, 2'b11, 16'hBEEF, lat);
    check("t1_lat", lat, 1);
    settle();
    check("t1_n", evq.size() - b, 1);
    if (evq.size() > b) begin
      check("t1_addr", 32'(evq[b].addr), 32'h100);
      check("t1_din", 32'(evq[b].din), 32'hBEEF);
      check("t1_be", 32'({evq[b].wrh, evq[b].wrl, evq[b].rd}), 32'b110);
      check("t1_hold", evq[b].fall - evq[b].rise, 5);
      check("t1_moved", 32'(evq[b].moved), 0);
    end

    // read from empty queue
    cpu_read(24'h000100, d, lat);
    check("t2_data", 32'(d), 32'hBEEF);
    check("t2_lat", lat, 7);
    settle();

    // five writes into a depth-4 queue, slow controller
    blen = 10;
    b = evq.size();
    for (int i = 0; i < 5; i++) begin
      cpu_write(24'h10 + 24'(i), 2'b11, 16'h1000 + 16'(i), lat);
      check(i < 4 ? "t3_lat" : "t3_lat5", lat, i < 4 ? 1 : 7);
    end
    settle();
    check("t3_n", evq.size() - b, 5);
    if (evq.size() >= b + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_order", 32'(evq[b+i].addr), 32'h10 + i);
        check("t3_data", 32'(evq[b+i].din), 32'h1000 + i);
      end
      check("t3_gap", evq[b+1].rise - evq[b].fall, 2);
    end

    // write then read the same word
    blen = 3;
    b = evq.size();
    cpu_write(24'h000200, 2'b11, 16'h1234, lat);
    cpu_read(24'h000200, d, lat);
    check("t4_data", 32'(d), 32'h1234);
    settle();
`ifndef SDRAM_WBUF_FWD_EN
    check("t4_n", evq.size() - b, 2);
    if (evq.size() >= b + 2) begin
      check("t4_rd", 32'(evq[b+1].rd), 1);
      check("t4_order", evq[b+1].rise - evq[b].fall, 2);
    end
`endif

    // byte writes
    b = evq.size();
    cpu_write(24'h000300, 2'b01, 16'hAA55, lat);
    settle();
    if (evq.size() > b)
      check("t5_lo", 32'({evq[b].wrh, evq[b].wrl}), 32'b01);
    cpu_write(24'h000300, 2'b10, 16'h1100, lat);
    settle();
    if (evq.size() > b + 1)
      check("t5_hi", 32'({evq[b+1].wrh, evq[b+1].wrl}), 32'b10);
    cpu_read(24'h000300, d, lat);
    check("t5_data", 32'(d), 32'h1155);
    settle();

    // reset while BUSY with entries queued
    blen = 20;
    for (int i = 0; i < 3; i++)
      cpu_write(24'h40 + 24'(i), 2'b11, 16'h4000 + 16'(i), lat);
    check("t6_busy", 32'(ram_wrl), 1);
    reset = 1'b1;
    #1;
    check("t6_stb", 32'({ram_rd, ram_wrl, ram_wrh}), 0);
    check("t6_addr", 32'(ram_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    a0 = acks;
    n  = evq.size();
    repeat (40) @(negedge clk);
    check("t6_ack", acks - a0, 0);
    check("t6_issue", evq.size() - n, 0);
    settle();

`ifdef SDRAM_WBUF_FWD_EN
    blen = 30;
    r0 = rds;
    cpu_write(24'h000400, 2'b11, 16'hCAFE, lat);
    cpu_read(24'h000400, d, lat);
    check("t7_lat", lat, 1);
    check("t7_data", 32'(d), 32'hCAFE);
    check("t7_nord", rds - r0, 0);
    cpu_write(24'h000400, 2'b01, 16'h0077, lat);
    cpu_read(24'h000400, d, lat);
    check("t7_pdata", 32'(d), 32'hCA77);
    check("t7_prd", rds - r0, 1);
    check("t7_plat", 32'(lat > 1), 1);
    settle();
`else
    r0 = rds;
    check("t7_rds", 32'(r0 >= 3), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
